// File: rtl/fifo_flags_if.sv
// fifo_flags_if: handshake and status bundle for fifo_flags.
//   master: producer/consumer side (drives rd, wr, w_data, clr_err)
//   slave : FIFO side (drives r_data, count, level and error flags)
interface fifo_flags_if #(
  parameter int B = 8,
  parameter int W = 4
);
  logic         rd;
  logic         wr;
  logic [B-1:0] w_data;
  logic         clr_err;
  logic [B-1:0] r_data;
  logic         empty;
  logic         full;
  logic         almost_empty;
  logic         almost_full;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  modport master (
    output rd, wr, w_data, clr_err,
    input  r_data, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  rd, wr, w_data, clr_err,
    output r_data, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_flags.sv
// fifo_flags: single-clock show-ahead FIFO, 2**W words of B bits, with
// occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset (pointers, count, flags)
//   bus   : fifo_flags_if slave modport
//           in : rd, wr, w_data, clr_err
//           out: r_data (head word, valid while empty=0), empty, full,
//                almost_empty, almost_full, count, overflow, underflow
module fifo_flags #(
  parameter int B      = 8,
  parameter int W      = 4,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         reset,
  fifo_flags_if.slave  bus
);

  localparam logic [W:0] DEPTH  = {1'b1, {W{1'b0}}};
  localparam logic [W:0] AF_THR = AF_LVL[W:0];
  localparam logic [W:0] AE_THR = AE_LVL[W:0];

  logic [B-1:0] mem [2**W];
  logic [W-1:0] w_ptr;
  logic [W-1:0] r_ptr;
  logic [W:0]   count_q;
  logic [W:0]   count_next;
  logic         empty_q;
  logic         full_q;
  logic         almost_empty_q;
  logic         almost_full_q;
  logic         overflow_q;
  logic         underflow_q;
  logic         push_ok;
  logic         pop_ok;

  // A push at full is allowed only when a pop frees the head slot on the
  // same edge; a pop at empty is always refused.
  always_comb begin
    push_ok    = bus.wr & (~full_q | bus.rd);
    pop_ok     = bus.rd & ~empty_q;
    count_next = count_q + (W+1)'(push_ok) - (W+1)'(pop_ok);
  end

  // Storage has no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[w_ptr] <= bus.w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr          <= '0;
      r_ptr          <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (push_ok) w_ptr <= w_ptr + 1'b1;
      if (pop_ok)  r_ptr <= r_ptr + 1'b1;
      count_q        <= count_next;
      // Level flags come from the next count so they move with count.
      empty_q        <= (count_next == '0);
      full_q         <= (count_next == DEPTH);
      almost_empty_q <= (count_next <= AE_THR);
      almost_full_q  <= (count_next >= AF_THR);
      // Set has priority over clear.
      if (bus.wr && full_q && !bus.rd) overflow_q <= 1'b1;
      else if (bus.clr_err)            overflow_q <= 1'b0;
      if (bus.rd && empty_q)           underflow_q <= 1'b1;
      else if (bus.clr_err)            underflow_q <= 1'b0;
    end
  end

  assign bus.r_data       = mem[r_ptr];
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: directed self-checking bench for fifo_flags (B=8, W=4,
// AF_LVL=14, AE_LVL=2). Inputs change 1 time unit after the rising edge;
// outputs are sampled at the same point.
module tb_fifo_flags;

  logic clk = 1'b0;
  logic reset;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  fifo_flags_if #(.B(8), .W(4)) bus ();

  fifo_flags #(.B(8), .W(4), .AF_LVL(14), .AE_LVL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then advance past the edge.
  task automatic cyc(input logic r, input logic w, input logic [7:0] d,
                     input logic clr, input logic rst);
    bus.rd      = r;
    bus.wr      = w;
    bus.w_data  = d;
    bus.clr_err = clr;
    reset       = rst;
    @(posedge clk);
    #1;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.clr_err = 1'b0;
    reset       = 1'b0;
  endtask

  initial begin
    int unsigned nxt_wr;
    int unsigned nxt_rd;
    int unsigned lvl;

    bus.rd = 1'b0; bus.wr = 1'b0; bus.w_data = '0; bus.clr_err = 1'b0;
    reset = 1'b1;
    #1;

    // Reset with wr held high
    cyc(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_ae",    32'(bus.almost_empty), 32'd1);
    check("rst_full",  32'(bus.full), 32'd0);
    check("rst_af",    32'(bus.almost_full), 32'd0);
    check("rst_ovf",   32'(bus.overflow), 32'd0);
    check("rst_unf",   32'(bus.underflow), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_nostore_empty", 32'(bus.empty), 32'd1);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_count", 32'(bus.count), 32'(i + 1));
      check("fill_af",    32'(bus.almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      check("fill_full",  32'(bus.full), (i + 1 == 16) ? 32'd1 : 32'd0);
      check("fill_head",  32'(bus.r_data), 32'h00);
    end

    // 17th push is dropped
    cyc(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    check("ovf_set",   32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("ovf_clr",   32'(bus.overflow), 32'd0);

    // Drain
    for (int i = 0; i < 16; i++) begin
      check("drain_data", 32'(bus.r_data), 32'(i));
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      check("drain_count", 32'(bus.count), 32'(15 - i));
      check("drain_ae",    32'(bus.almost_empty), (15 - i <= 2) ? 32'd1 : 32'd0);
      check("drain_empty", 32'(bus.empty), (i == 15) ? 32'd1 : 32'd0);
    end
    check("drain_unf", 32'(bus.underflow), 32'd0);

    // Simultaneous push/pop at full
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    check("full_pre", 32'(bus.full), 32'd1);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    check("full_rw_count", 32'(bus.count), 32'd16);
    check("full_rw_ovf",   32'(bus.overflow), 32'd0);
    check("full_rw_full",  32'(bus.full), 32'd1);
    for (int i = 1; i < 17; i++) begin
      check("full_rw_data", 32'(bus.r_data), (i == 16) ? 32'hAA : 32'(i));
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("full_rw_empty", 32'(bus.empty), 32'd1);

    // Simultaneous push/pop at empty
    cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    check("empty_rw_count", 32'(bus.count), 32'd1);
    check("empty_rw_unf",   32'(bus.underflow), 32'd1);
    check("empty_rw_empty", 32'(bus.empty), 32'd0);
    check("empty_rw_data",  32'(bus.r_data), 32'h55);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("empty_rw_drain", 32'(bus.count), 32'd0);

    // Sticky underflow
    repeat (10) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("unf_sticky", 32'(bus.underflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_clr", 32'(bus.underflow), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set_wins", 32'(bus.underflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_clr2", 32'(bus.underflow), 32'd0);

    // Wrap-around: preload 4, then push+pop / push / pop pattern
    nxt_wr = 0;
    nxt_rd = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'(nxt_wr), 1'b0, 1'b0);
      nxt_wr++;
    end
    for (int k = 0; k < 40; k++) begin
      logic r;
      logic w;
      r = (k % 3 != 1);
      w = (k % 3 != 2);
      if (r) begin
        check("wrap_data", 32'(bus.r_data), 32'(8'(nxt_rd)));
        nxt_rd++;
      end
      cyc(r, w, 8'(nxt_wr), 1'b0, 1'b0);
      if (w) nxt_wr++;
      lvl = 32'(bus.count);
      check("wrap_level", (lvl >= 3 && lvl <= 5) ? 32'd1 : 32'd0, 32'd1);
    end
    check("wrap_count", 32'(bus.count), 32'(nxt_wr - nxt_rd));
    while (nxt_rd < nxt_wr) begin
      check("wrap_tail", 32'(bus.r_data), 32'(8'(nxt_rd)));
      nxt_rd++;
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("wrap_empty", 32'(bus.empty), 32'd1);
    check("wrap_unf",   32'(bus.underflow), 32'd0);

    // Mid-operation reset
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    check("mid_pre_count", 32'(bus.count), 32'd7);
    cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    check("mid_new_data",  32'(bus.r_data), 32'h77);
    check("mid_new_count", 32'(bus.count), 32'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("mid_pop_empty", 32'(bus.empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
